sfifo_wr_control: RTL and testbench
===================================

# sfifo_wr_control

Write-side pointer controller for the synchronous FIFO. It accepts producer write requests and gates them against the read controller's pointer. It advances the extended (AddrLines+1)-bit write pointer and drives the RAM write address. It also reports full, almost-full, fill level, a high-water mark and overflow status, and sits opposite the read controller, sharing the same memory.

## Interface
- AddrLines, 8, RAM address width; depth = 2^AddrLines
- AFThresh, 2^AddrLines-2, fill level at or above which FIFOAlmostFull asserts; legal range 1..2^AddrLines
- DropCntW, 16, width of the overflow drop counter
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  reset, synchronous and active-high
- FIFOWrReq  in  1  producer write request, one word per cycle
- SyncRdAddr  in  AddrLines+1  read controller's extended read pointer, same clock domain
- OvfClr  in  1  clears Overflow and DropCount
- HwmClr  in  1  clears HighWater
- WrEn  out  1  RAM write strobe
- WrAddr  out  AddrLines  RAM write address = SyncWrAddr[AddrLines-1:0]
- SyncWrAddr  out  AddrLines+1  extended write pointer, registered; goes to the read controller
- FIFOFull  out  1  FIFO full
- FIFOAlmostFull  out  1  FillLevel >= AFThresh
- FillLevel  out  AddrLines+1  words stored, range 0..2^AddrLines
- HighWater  out  AddrLines+1  maximum FillLevel since the last clear
- Overflow  out  1  sticky; a write was refused
- DropCount  out  DropCntW  saturating count of refused writes

## Operation
- FIFOFull = (SyncWrAddr[AddrLines] != SyncRdAddr[AddrLines]) && (SyncWrAddr[AddrLines-1:0] == SyncRdAddr[AddrLines-1:0]).
- WrEn = FIFOWrReq && !FIFOFull. This is combinational, in the same cycle as the request.
- On WrEn, SyncWrAddr <= SyncWrAddr + 1, modulo 2^(AddrLines+1). Wrap from all-ones to 0 is natural and flips the MSB.
- FillLevel = SyncWrAddr - SyncRdAddr, computed modulo 2^(AddrLines+1). It is combinational from the registered pointers.
- FIFOAlmostFull is combinational from FillLevel. FIFOFull implies FIFOAlmostFull.
- Refused write: FIFOWrReq && FIFOFull.
  - Overflow <= 1.
  - DropCount <= DropCount + 1, saturating at 2^DropCntW-1.
  - The pointer does not move.
- OvfClr clears Overflow and DropCount. If OvfClr and a refused write occur in the same cycle, the result is Overflow=1 and DropCount=1, so the new event is not lost.
- HighWater updates every cycle: HighWater <= max(HighWater, FillLevel). HwmClr loads the current FillLevel rather than 0.
- The controller has no knowledge of reads beyond SyncRdAddr. A simultaneous read and write at full is refused; the write side sees full until the read pointer has advanced.

## Timing
- Reset values: SyncWrAddr=0, Overflow=0, DropCount=0, HighWater=0.
- Derived outputs after reset, with SyncRdAddr=0: WrAddr=0, FillLevel=0, FIFOFull=0, FIFOAlmostFull=0, WrEn=FIFOWrReq.
- Reset has priority over every other input. Asserting reset mid-stream zeroes all registers on the next edge. The read controller must be reset in the same cycle.
- Latency:
  - WrEn follows FIFOWrReq with zero cycles.
  - SyncWrAddr, FillLevel and FIFOFull update one cycle after WrEn.
  - Overflow and DropCount update one cycle after the refused request.
  - HighWater lags FillLevel by one cycle.
- Back-to-back writes are sustained at one word per clock until full.
- A change in SyncRdAddr takes effect on FIFOFull in the same cycle, combinationally.

## Structure
- Shared package sfifo_pkg holds:
  - the extended-pointer width expression AddrLines+1
  - the full/empty compare as functions shared with the read controller
  - the DropCntW default
- One sub-module is natural: sfifo_sat_counter, a parameterized-width saturating counter with synchronous clear, used for DropCount.
- Everything else is flat.

## Test plan
All scenarios use AddrLines=3, AFThresh=6.
- Reset, then idle: all outputs 0. FIFOWrReq=1 for one cycle gives WrEn=1 and WrAddr=0; next cycle SyncWrAddr=1 and FillLevel=1.
- 8 consecutive writes with SyncRdAddr=0:
  - FIFOAlmostFull rises when FillLevel=6.
  - After the 8th write, SyncWrAddr=4'b1000 and FIFOFull=1.
  - A 9th request gives WrEn=0; next cycle Overflow=1 and DropCount=1.
- Wrap-around:
  - Drive SyncRdAddr to follow writes until SyncWrAddr=15.
  - One more write gives SyncWrAddr=0 and WrAddr=0.
  - FillLevel stays correct at each step, e.g. W=0, R=14 gives 2.
- At full, request continuously, then step SyncRdAddr by 1:
  - FIFOFull drops in that same cycle and WrEn=1.
  - DropCount stops incrementing.
- OvfClr asserted in the same cycle as a refused write gives Overflow=1 and DropCount=1. OvfClr alone gives 0 and 0.
- Fill to 5, HwmClr, drain to 2:
  - HighWater=5 before the clear.
  - After the clear, HighWater follows the current level, then holds the maximum seen.
- Reset asserted mid-stream: all registers return to 0 on the next edge.

Source files
------------

// File: rtl/sfifo_pkg.sv
// Shared definitions for the synchronous FIFO write and read controllers.
// Extended pointers carry one wrap bit above the RAM address.
package sfifo_pkg;

  localparam int DROP_CNT_W_DEFAULT = 16;

  // Pointers are zero-extended to this width before being compared.
  localparam int PTR_MAX_W = 32;

  function automatic int ptr_width(input int addr_lines);
    return addr_lines + 1;
  endfunction

  // Full: the wrap bits differ and the address bits match.
  function automatic logic ptr_full(input logic [PTR_MAX_W-1:0] wr_ptr,
                                    input logic [PTR_MAX_W-1:0] rd_ptr,
                                    input int addr_lines);
    logic [PTR_MAX_W-1:0] diff;
    logic [PTR_MAX_W-1:0] wrap_bit;
    diff     = wr_ptr ^ rd_ptr;
    wrap_bit = PTR_MAX_W'(1) << addr_lines;
    return diff == wrap_bit;
  endfunction

  function automatic logic ptr_empty(input logic [PTR_MAX_W-1:0] wr_ptr,
                                     input logic [PTR_MAX_W-1:0] rd_ptr);
    return wr_ptr == rd_ptr;
  endfunction

endpackage

// File: rtl/sfifo_sat_counter.sv
// Saturating up-counter with synchronous clear.
// A clear and an increment in the same cycle leave the count at 1.
module sfifo_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MaxCnt = '1;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? W'(1) : '0;
    end else if (inc && (count != MaxCnt)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/sfifo_wr_control.sv
// Write-side pointer controller for the synchronous FIFO: gates producer
// writes against the read pointer and reports fill, high-water and overflow.
module sfifo_wr_control
  import sfifo_pkg::*;
#(
  parameter int AddrLines = 8,
  parameter int AFThresh  = (1 << AddrLines) - 2,
  parameter int DropCntW  = DROP_CNT_W_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                FIFOWrReq,
  input  logic [AddrLines:0]  SyncRdAddr,
  input  logic                OvfClr,
  input  logic                HwmClr,
  output logic                WrEn,
  output logic [AddrLines-1:0] WrAddr,
  output logic [AddrLines:0]  SyncWrAddr,
  output logic                FIFOFull,
  output logic                FIFOAlmostFull,
  output logic [AddrLines:0]  FillLevel,
  output logic [AddrLines:0]  HighWater,
  output logic                Overflow,
  output logic [DropCntW-1:0] DropCount
);

  localparam int PtrW = ptr_width(AddrLines);
  localparam logic [PtrW-1:0] AfLevel = PtrW'(AFThresh);

  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] hw_q;
  logic            ovf_q;
  logic            full;
  logic            refused;

  // Full reacts to the read pointer in the same cycle it moves.
  assign full    = ptr_full(PTR_MAX_W'(wr_ptr), PTR_MAX_W'(SyncRdAddr), AddrLines);
  assign WrEn    = FIFOWrReq && !full;
  assign refused = FIFOWrReq && full;

  assign FillLevel      = wr_ptr - SyncRdAddr;
  assign FIFOAlmostFull = FillLevel >= AfLevel;
  assign FIFOFull       = full;
  assign SyncWrAddr     = wr_ptr;
  assign WrAddr         = wr_ptr[AddrLines-1:0];
  assign HighWater      = hw_q;
  assign Overflow       = ovf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
    end else if (WrEn) begin
      wr_ptr <= wr_ptr + PtrW'(1);
    end
  end

  // A refusal in the same cycle as the clear wins so the event is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (refused) begin
      ovf_q <= 1'b1;
    end else if (OvfClr) begin
      ovf_q <= 1'b0;
    end
  end

  // Clearing restarts tracking from the present level, not from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      hw_q <= '0;
    end else if (HwmClr) begin
      hw_q <= FillLevel;
    end else if (FillLevel > hw_q) begin
      hw_q <= FillLevel;
    end
  end

  sfifo_sat_counter #(
    .W (DropCntW)
  ) u_drop_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (OvfClr),
    .inc   (refused),
    .count (DropCount)
  );

endmodule

// File: tb/tb_sfifo_wr_control.sv
// Directed bench for sfifo_wr_control with AddrLines=3, AFThresh=6 and a
// 3-bit drop counter so saturation is reachable.
module tb_sfifo_wr_control;

  logic       clk;
  logic       reset;
  logic       FIFOWrReq;
  logic [3:0] SyncRdAddr;
  logic       OvfClr;
  logic       HwmClr;
  logic       WrEn;
  logic [2:0] WrAddr;
  logic [3:0] SyncWrAddr;
  logic       FIFOFull;
  logic       FIFOAlmostFull;
  logic [3:0] FillLevel;
  logic [3:0] HighWater;
  logic       Overflow;
  logic [2:0] DropCount;

  int checks = 0;
  int errors = 0;

  sfifo_wr_control #(
    .AddrLines (3),
    .AFThresh  (6),
    .DropCntW  (3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .FIFOWrReq      (FIFOWrReq),
    .SyncRdAddr     (SyncRdAddr),
    .OvfClr         (OvfClr),
    .HwmClr         (HwmClr),
    .WrEn           (WrEn),
    .WrAddr         (WrAddr),
    .SyncWrAddr     (SyncWrAddr),
    .FIFOFull       (FIFOFull),
    .FIFOAlmostFull (FIFOAlmostFull),
    .FillLevel      (FillLevel),
    .HighWater      (HighWater),
    .Overflow       (Overflow),
    .DropCount      (DropCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       req;
    logic       oclr;
    logic       hclr;
    logic [3:0] rd;
    logic       we;
    logic [3:0] w;
    logic       full;
    logic       af;
    logic [3:0] fill;
    logic [3:0] hw;
    logic       ovf;
    logic [2:0] drop;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int rst, input int req, input int oclr, input int hclr,
                              input int rd, input int we, input int w, input int full,
                              input int af, input int fill, input int hw, input int ovf,
                              input int drop);
    vec_t v;
    v.rst  = 1'(rst);
    v.req  = 1'(req);
    v.oclr = 1'(oclr);
    v.hclr = 1'(hclr);
    v.rd   = 4'(rd);
    v.we   = 1'(we);
    v.w    = 4'(w);
    v.full = 1'(full);
    v.af   = 1'(af);
    v.fill = 4'(fill);
    v.hw   = 4'(hw);
    v.ovf  = 1'(ovf);
    v.drop = 3'(drop);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int req, input int rd, input int oclr, input int hclr);
    FIFOWrReq  = 1'(req);
    SyncRdAddr = 4'(rd);
    OvfClr     = 1'(oclr);
    HwmClr     = 1'(hclr);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    FIFOWrReq = 1'b0;
    SyncRdAddr = '0;
    OvfClr = 1'b0;
    HwmClr = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    //             rst req oc hc rd  we w  full af fill hw ovf drop
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,  1, 1, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,  1, 2, 0, 0, 2, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,  1, 3, 0, 0, 3, 2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,  1, 4, 0, 0, 4, 3, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,  1, 5, 0, 0, 5, 4, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,  1, 6, 0, 1, 6, 5, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,  1, 7, 0, 1, 7, 6, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,  0, 8, 1, 1, 8, 7, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 8, 1, 1, 8, 8, 1, 1));
    vecs.push_back(mk(0, 1, 1, 0, 0,  0, 8, 1, 1, 8, 8, 1, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0,  0, 8, 1, 1, 8, 8, 1, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0,  0, 8, 1, 1, 8, 8, 1, 2));
    vecs.push_back(mk(0, 0, 1, 0, 0,  0, 8, 1, 1, 8, 8, 1, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 8, 1, 1, 8, 8, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,  0, 8, 1, 1, 8, 8, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1,  1, 8, 0, 1, 7, 8, 1, 1));
    vecs.push_back(mk(0, 1, 0, 0, 1,  0, 9, 1, 1, 8, 8, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1,  0, 9, 1, 1, 8, 8, 1, 2));
    vecs.push_back(mk(1, 0, 0, 0, 1,  0, 9, 1, 1, 8, 8, 1, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      drive(vecs[i].req, vecs[i].rd, vecs[i].oclr, vecs[i].hclr);
      chk($sformatf("v%0d WrEn", i), WrEn, vecs[i].we);
      chk($sformatf("v%0d WrAddr", i), WrAddr, int'(vecs[i].w[2:0]));
      chk($sformatf("v%0d SyncWrAddr", i), SyncWrAddr, vecs[i].w);
      chk($sformatf("v%0d FIFOFull", i), FIFOFull, vecs[i].full);
      chk($sformatf("v%0d FIFOAlmostFull", i), FIFOAlmostFull, vecs[i].af);
      chk($sformatf("v%0d FillLevel", i), FillLevel, vecs[i].fill);
      chk($sformatf("v%0d HighWater", i), HighWater, vecs[i].hw);
      chk($sformatf("v%0d Overflow", i), Overflow, vecs[i].ovf);
      chk($sformatf("v%0d DropCount", i), DropCount, vecs[i].drop);
      tick();
    end
    reset = 1'b0;

    // Wrap-around: read pointer trails the write pointer by two.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      drive(1, (k >= 2) ? k - 2 : 0, 0, 0);
      chk($sformatf("wrap%0d WrEn", k), WrEn, 1);
      chk($sformatf("wrap%0d SyncWrAddr", k), SyncWrAddr, k);
      chk($sformatf("wrap%0d WrAddr", k), WrAddr, k % 8);
      chk($sformatf("wrap%0d FillLevel", k), FillLevel, (k >= 2) ? 2 : k);
      tick();
    end
    drive(0, 14, 0, 0);
    chk("wrap_end SyncWrAddr", SyncWrAddr, 0);
    chk("wrap_end WrAddr", WrAddr, 0);
    chk("wrap_end FillLevel", FillLevel, 2);
    chk("wrap_end FIFOFull", FIFOFull, 0);
    tick();

    // Drop counter saturation at 7.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(1, 0, 0, 0);
      tick();
    end
    for (int k = 0; k < 7; k++) begin
      drive(1, 0, 0, 0);
      tick();
    end
    drive(1, 0, 0, 0);
    chk("sat7 DropCount", DropCount, 7);
    tick();
    drive(1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    chk("sat_hold DropCount", DropCount, 7);
    chk("sat_hold Overflow", Overflow, 1);
    chk("sat_hold SyncWrAddr", SyncWrAddr, 8);

    // High-water: fill to 5, drain to 3 with clear, drain to 2, refill.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0);
    chk("hwm_lag HighWater", HighWater, 4);
    tick();
    drive(0, 2, 0, 1);
    chk("hwm_pre FillLevel", FillLevel, 3);
    chk("hwm_pre HighWater", HighWater, 5);
    tick();
    drive(0, 3, 0, 0);
    chk("hwm_clr HighWater", HighWater, 3);
    chk("hwm_clr FillLevel", FillLevel, 2);
    tick();
    drive(1, 3, 0, 0);
    chk("hwm_hold HighWater", HighWater, 3);
    tick();
    drive(1, 3, 0, 0);
    chk("hwm_w1 FillLevel", FillLevel, 3);
    chk("hwm_w1 HighWater", HighWater, 3);
    tick();
    drive(0, 3, 0, 0);
    chk("hwm_w2 FillLevel", FillLevel, 4);
    tick();
    drive(0, 3, 0, 0);
    chk("hwm_rise HighWater", HighWater, 4);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
